// File: rtl/k12a_spi_queue.sv
// TX/RX byte queues in front of the k12a_spi peripheral, plus a sequencer that
// runs one full-duplex byte per transfer through the peripheral's strobes.
module k12a_spi_queue #(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic       cpu_clock,
    input  logic       reset,
    input  logic       tx_wr,
    input  logic [7:0] wr_data,
    input  logic       rx_rd,
    output logic [7:0] rd_data,
    output logic       tx_full,
    output logic       tx_empty,
    output logic       rx_full,
    output logic       rx_empty,
    output logic       overflow,
    input  logic       clear_overflow,
    output logic       idle,
    output logic       spi_data_io_store,
    output logic       spi_begin,
    output logic       spi_data_io_load,
    input  logic       spi_busy,
    output logic [7:0] spi_data_out,
    output logic       spi_data_oe,
    input  logic [7:0] spi_data_in
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STORE,
        ST_BEGIN,
        ST_GUARD,
        ST_DRAIN,
        ST_LOAD
    } state_t;

    state_t state_q, state_d;

    logic [7:0]       tx_mem_q [DEPTH];
    logic [PTR_W-1:0] tx_wptr_q, tx_rptr_q;
    logic [PTR_W:0]   tx_cnt_q, tx_cnt_d;
    logic [7:0]       rx_mem_q [DEPTH];
    logic [PTR_W-1:0] rx_wptr_q, rx_rptr_q;
    logic [PTR_W:0]   rx_cnt_q, rx_cnt_d;
    logic             overflow_q, overflow_d;
    logic             store_q, begin_q, load_q, oe_q;
    logic [7:0]       dout_q;
    logic             tx_push, tx_pop, rx_push, rx_pop;
    logic [7:0]       tx_head;

    assign tx_full  = (tx_cnt_q == FULL_CNT);
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == FULL_CNT);
    assign rx_empty = (rx_cnt_q == '0);

    // A push that meets a full TX FIFO is dropped even if STORE pops this cycle.
    assign tx_push = tx_wr && !tx_full && !reset;
    assign tx_pop  = (state_q == ST_STORE);
    assign rx_push = (state_q == ST_LOAD) && !rx_full && !reset;
    assign rx_pop  = rx_rd && !rx_empty;
    assign tx_head = tx_mem_q[tx_rptr_q];

    assign rd_data           = rx_empty ? 8'h00 : rx_mem_q[rx_rptr_q];
    assign overflow          = overflow_q;
    assign idle              = (state_q == ST_IDLE) && tx_empty && !spi_busy;
    assign spi_data_io_store = store_q;
    assign spi_begin         = begin_q;
    assign spi_data_io_load  = load_q;
    assign spi_data_oe       = oe_q;
    assign spi_data_out      = dout_q;

    always_comb begin
        tx_cnt_d = tx_cnt_q;
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
            2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
            default: tx_cnt_d = tx_cnt_q;
        endcase
        rx_cnt_d = rx_cnt_q;
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
            2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
            default: rx_cnt_d = rx_cnt_q;
        endcase
        // A set in the same cycle as a clear must win.
        overflow_d = overflow_q;
        if (clear_overflow) overflow_d = 1'b0;
        if (tx_wr && tx_full) overflow_d = 1'b1;
    end

    always_ff @(posedge cpu_clock) begin
        if (tx_push) tx_mem_q[tx_wptr_q] <= wr_data;
        if (rx_push) rx_mem_q[rx_wptr_q] <= spi_data_in;
    end

    always_ff @(posedge cpu_clock) begin
        if (reset) begin
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_cnt_q   <= '0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_cnt_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (tx_push) tx_wptr_q <= tx_wptr_q + PTR_W'(1);
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + PTR_W'(1);
            if (rx_push) rx_wptr_q <= rx_wptr_q + PTR_W'(1);
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + PTR_W'(1);
            tx_cnt_q   <= tx_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // GUARD ignores spi_busy for one cycle while the peripheral raises it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!tx_empty && !rx_full && !spi_busy) state_d = ST_STORE;
            ST_STORE: state_d = ST_BEGIN;
            ST_BEGIN: state_d = ST_GUARD;
            ST_GUARD: state_d = ST_DRAIN;
            ST_DRAIN: if (!spi_busy) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            store_q <= 1'b0;
            begin_q <= 1'b0;
            load_q  <= 1'b0;
            oe_q    <= 1'b0;
            dout_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            store_q <= (state_d == ST_STORE);
            begin_q <= (state_d == ST_BEGIN);
            load_q  <= (state_d == ST_LOAD);
            oe_q    <= (state_d == ST_STORE);
            dout_q  <= (state_d == ST_STORE) ? tx_head : 8'h00;
        end
    end

endmodule

// File: tb/tb_k12a_spi_queue.sv
// Directed bench for k12a_spi_queue with a small peripheral model that holds
// spi_busy for busy_len cycles after begin and returns the stored byte XOR mask.
module tb_k12a_spi_queue;

    logic       cpu_clock = 1'b0;
    logic       reset = 1'b1;
    logic       tx_wr = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rx_rd = 1'b0;
    logic [7:0] rd_data;
    logic       tx_full, tx_empty, rx_full, rx_empty, overflow;
    logic       clear_overflow = 1'b0;
    logic       idle;
    logic       spi_data_io_store, spi_begin, spi_data_io_load;
    logic       spi_busy;
    logic [7:0] spi_data_out;
    logic       spi_data_oe;
    logic [7:0] spi_data_in;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    // peripheral model state
    logic       model_busy = 1'b0;
    logic       force_busy = 1'b0;
    int         busy_len = 16;
    int         busy_cnt = 0;
    logic [7:0] cap = 8'h00;
    logic [7:0] mask = 8'h00;

    // monitor state
    int n_store = 0, n_begin = 0, n_load = 0;
    int order_err = 0, multi_err = 0, busy_store_err = 0, oe_err = 0;
    int last_code = 3;
    logic [7:0] last_store_data = 8'h00;

    assign spi_busy    = model_busy | force_busy;
    assign spi_data_in = cap ^ mask;

    k12a_spi_queue #(.DEPTH(4)) dut (
        .cpu_clock(cpu_clock), .reset(reset), .tx_wr(tx_wr), .wr_data(wr_data),
        .rx_rd(rx_rd), .rd_data(rd_data), .tx_full(tx_full), .tx_empty(tx_empty),
        .rx_full(rx_full), .rx_empty(rx_empty), .overflow(overflow),
        .clear_overflow(clear_overflow), .idle(idle),
        .spi_data_io_store(spi_data_io_store), .spi_begin(spi_begin),
        .spi_data_io_load(spi_data_io_load), .spi_busy(spi_busy),
        .spi_data_out(spi_data_out), .spi_data_oe(spi_data_oe), .spi_data_in(spi_data_in)
    );

    // clock / reset block
    always #5 cpu_clock = ~cpu_clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge cpu_clock) begin
        if (spi_data_io_store) cap = spi_data_out;
        if (spi_begin) begin
            busy_cnt   = busy_len;
            model_busy = 1'b1;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) model_busy = 1'b0;
        end
    end

    always @(negedge cpu_clock) begin
        if (reset) begin
            last_code = 3;
        end else begin
            if ((32'(spi_data_io_store) + 32'(spi_begin) + 32'(spi_data_io_load)) > 1) multi_err++;
            if (spi_data_io_store) begin
                if (last_code != 3) order_err++;
                last_code = 1;
                n_store++;
                last_store_data = spi_data_out;
                if (!spi_data_oe) oe_err++;
                if (spi_busy) busy_store_err++;
            end else if (spi_data_oe || spi_data_out != 8'h00) begin
                oe_err++;
            end
            if (spi_begin) begin
                if (last_code != 1) order_err++;
                last_code = 2;
                n_begin++;
            end
            if (spi_data_io_load) begin
                if (last_code != 2) order_err++;
                last_code = 3;
                n_load++;
            end
        end
    end

    // driver tasks
    task automatic push_byte(input logic [7:0] b);
        tx_wr = 1'b1;
        wr_data = b;
        @(posedge cpu_clock);
        #1 tx_wr = 1'b0;
    endtask

    task automatic pop_byte();
        rx_rd = 1'b1;
        @(posedge cpu_clock);
        #1 rx_rd = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge cpu_clock);
            if (idle) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_loads(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge cpu_clock);
            if (n_load >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; tx_wr = 1'b1; wr_data = 8'h77; rx_rd = 1'b1;
        repeat (2) @(posedge cpu_clock);
        @(negedge cpu_clock);
        checks++; if (tx_empty !== 1'b1) begin errors++; $display("FAIL reset_tx_empty got %b exp 1", tx_empty); end
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL reset_rx_empty got %b exp 1", rx_empty); end
        checks++; if ({tx_full, rx_full} !== 2'b00) begin errors++; $display("FAIL reset_full got %b exp 00", {tx_full, rx_full}); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        checks++; if ({spi_data_io_store, spi_begin, spi_data_io_load, spi_data_oe} !== 4'b0000) begin
            errors++; $display("FAIL reset_strobes got %b exp 0000", {spi_data_io_store, spi_begin, spi_data_io_load, spi_data_oe}); end
        checks++; if (spi_data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out got %h exp 00", spi_data_out); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h exp 00", rd_data); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b exp 1", idle); end
        tx_wr = 1'b0; rx_rd = 1'b0;
        @(posedge cpu_clock);
        #1 reset = 1'b0;
        @(negedge cpu_clock);
        checks++; if (tx_empty !== 1'b1) begin errors++; $display("FAIL reset_release_tx_empty got %b exp 1", tx_empty); end
    endtask

    task automatic test_single_byte();
        int s0, b0, l0, ord0, mul0, oe0;
        bit ok;
        mask = 8'h99; busy_len = 16;
        s0 = n_store; b0 = n_begin; l0 = n_load; ord0 = order_err; mul0 = multi_err; oe0 = oe_err;
        push_byte(8'hA5);
        wait_idle(200, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_timeout got %b exp 1", ok); end
        checks++; if ((n_store - s0) != 1 || (n_begin - b0) != 1 || (n_load - l0) != 1) begin
            errors++; $display("FAIL single_strobe_counts got %0d/%0d/%0d exp 1/1/1", n_store - s0, n_begin - b0, n_load - l0); end
        checks++; if ((order_err - ord0) != 0 || (multi_err - mul0) != 0) begin
            errors++; $display("FAIL single_strobe_order got %0d/%0d exp 0/0", order_err - ord0, multi_err - mul0); end
        checks++; if ((oe_err - oe0) != 0) begin errors++; $display("FAIL single_oe got %0d exp 0", oe_err - oe0); end
        checks++; if (last_store_data !== 8'hA5) begin errors++; $display("FAIL single_store_data got %h exp a5", last_store_data); end
        checks++; if (rx_empty !== 1'b0) begin errors++; $display("FAIL single_rx_empty got %b exp 0", rx_empty); end
        checks++; if (rd_data !== 8'h3C) begin errors++; $display("FAIL single_rd_data got %h exp 3c", rd_data); end
        checks++; if (idle !== 1'b1 || tx_empty !== 1'b1) begin errors++; $display("FAIL single_idle got %b%b exp 11", idle, tx_empty); end
        pop_byte();
        @(negedge cpu_clock);
        checks++; if (rx_empty !== 1'b1 || rd_data !== 8'h00) begin
            errors++; $display("FAIL single_after_pop got %b %h exp 1 00", rx_empty, rd_data); end
    endtask

    task automatic test_overflow();
        int s0, l0;
        bit ok;
        mask = 8'h00; busy_len = 3;
        s0 = n_store; l0 = n_load;
        force_busy = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            push_byte(8'(i));
            if (i <= 4) exp_q.push_back(8'(i));
        end
        @(negedge cpu_clock);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
        checks++; if (tx_full !== 1'b1 || tx_empty !== 1'b0) begin errors++; $display("FAIL ovf_tx_full got %b%b exp 10", tx_full, tx_empty); end
        checks++; if ((n_store - s0) != 0) begin errors++; $display("FAIL ovf_no_start got %0d exp 0", n_store - s0); end
        // overflow set and clear in the same cycle: set wins
        clear_overflow = 1'b1;
        push_byte(8'h06);
        clear_overflow = 1'b0;
        @(negedge cpu_clock);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %b exp 1", overflow); end
        clear_overflow = 1'b1;
        @(posedge cpu_clock);
        #1 clear_overflow = 1'b0;
        @(negedge cpu_clock);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
        force_busy = 1'b0;
        wait_idle(400, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ovf_timeout got %b exp 1", ok); end
        checks++; if ((n_load - l0) != 4) begin errors++; $display("FAIL ovf_transfers got %0d exp 4", n_load - l0); end
        checks++; if (rx_full !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_rx_full got %b%b exp 10", rx_full, overflow); end
        for (int i = 0; i < 4; i++) begin
            logic [7:0] e;
            @(negedge cpu_clock);
            e = exp_q.pop_front();
            checks++; if (rx_empty !== 1'b0 || rd_data !== e) begin
                errors++; $display("FAIL ovf_rx_data got %b %h exp 0 %h", rx_empty, rd_data, e); end
            pop_byte();
        end
        @(negedge cpu_clock);
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL ovf_rx_drained got %b exp 1", rx_empty); end
    endtask

    task automatic test_rx_backpressure();
        int s0, l0;
        bit ok;
        mask = 8'h00; busy_len = 3;
        s0 = n_store; l0 = n_load;
        for (int i = 0; i < 4; i++) begin
            push_byte(8'h20 + 8'(i));
            exp_q.push_back(8'h20 + 8'(i));
        end
        for (int i = 4; i < 6; i++) begin
            ok = 1'b0;
            for (int c = 0; c < 200; c++) begin
                @(negedge cpu_clock);
                if (!tx_full) begin ok = 1'b1; break; end
            end
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bp_tx_space got %b exp 1", ok); end
            push_byte(8'h20 + 8'(i));
            exp_q.push_back(8'h20 + 8'(i));
        end
        wait_loads(l0 + 4, 400, ok);
        repeat (60) @(negedge cpu_clock);
        checks++; if ((n_load - l0) != 4 || (n_store - s0) != 4) begin
            errors++; $display("FAIL bp_four_transfers got %0d/%0d exp 4/4", n_store - s0, n_load - l0); end
        checks++; if (rx_full !== 1'b1 || tx_empty !== 1'b0 || idle !== 1'b0) begin
            errors++; $display("FAIL bp_hold got %b%b%b exp 100", rx_full, tx_empty, idle); end
        checks++; if (rd_data !== exp_q[0]) begin errors++; $display("FAIL bp_head got %h exp %h", rd_data, exp_q[0]); end
        void'(exp_q.pop_front());
        pop_byte();
        wait_loads(l0 + 5, 200, ok);
        repeat (60) @(negedge cpu_clock);
        checks++; if ((n_load - l0) != 5 || rx_full !== 1'b1) begin
            errors++; $display("FAIL bp_one_more got %0d %b exp 5 1", n_load - l0, rx_full); end
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            ok = 1'b0;
            for (int c = 0; c < 400; c++) begin
                @(negedge cpu_clock);
                if (!rx_empty) begin ok = 1'b1; break; end
            end
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bp_drain_timeout got %b exp 1", ok); break; end
            e = exp_q.pop_front();
            checks++; if (rd_data !== e) begin errors++; $display("FAIL bp_drain_data got %h exp %h", rd_data, e); end
            pop_byte();
        end
        @(negedge cpu_clock);
        checks++; if ((n_load - l0) != 6 || rx_empty !== 1'b1 || tx_empty !== 1'b1) begin
            errors++; $display("FAIL bp_final got %0d %b%b exp 6 11", n_load - l0, rx_empty, tx_empty); end
    endtask

    task automatic test_pointer_wrap();
        int l0;
        mask = 8'h00; busy_len = 2;
        l0 = n_load;
        exp_q.delete();
        for (int i = 0; i < 10; i++) exp_q.push_back(8'h10 + 8'(i));
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    bit got;
                    got = 1'b0;
                    for (int c = 0; c < 400; c++) begin
                        @(negedge cpu_clock);
                        if (!tx_full) begin got = 1'b1; break; end
                    end
                    if (!got) begin errors++; $display("FAIL wrap_push_timeout got 0 exp 1"); break; end
                    push_byte(8'h10 + 8'(k));
                end
            end
            begin
                for (int k = 0; k < 10; k++) begin
                    bit got;
                    logic [7:0] e;
                    got = 1'b0;
                    for (int c = 0; c < 400; c++) begin
                        @(negedge cpu_clock);
                        if (!rx_empty) begin got = 1'b1; break; end
                    end
                    checks++; if (!got) begin errors++; $display("FAIL wrap_pop_timeout got 0 exp 1"); break; end
                    e = exp_q.pop_front();
                    checks++; if (rd_data !== e) begin errors++; $display("FAIL wrap_data got %h exp %h", rd_data, e); end
                    pop_byte();
                end
            end
        join
        @(negedge cpu_clock);
        checks++; if ((n_load - l0) != 10 || exp_q.size() != 0) begin
            errors++; $display("FAIL wrap_count got %0d left %0d exp 10 0", n_load - l0, exp_q.size()); end
        checks++; if (rx_empty !== 1'b1 || tx_empty !== 1'b1) begin
            errors++; $display("FAIL wrap_empty got %b%b exp 11", rx_empty, tx_empty); end
    endtask

    task automatic test_reset_in_drain();
        int l0, bs0;
        bit ok;
        mask = 8'h00; busy_len = 12;
        push_byte(8'h5A);
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge cpu_clock);
            if (spi_begin) begin ok = 1'b1; break; end
        end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL drain_begin_timeout got %b exp 1", ok); end
        repeat (6) @(negedge cpu_clock);
        @(posedge cpu_clock);
        #1 reset = 1'b1;
        @(posedge cpu_clock);
        #1 reset = 1'b0;
        @(negedge cpu_clock);
        checks++; if ({spi_data_io_store, spi_begin, spi_data_io_load, spi_data_oe} !== 4'b0000 || spi_data_out !== 8'h00) begin
            errors++; $display("FAIL drain_strobes got %b %h exp 0000 00",
                               {spi_data_io_store, spi_begin, spi_data_io_load, spi_data_oe}, spi_data_out); end
        checks++; if (tx_empty !== 1'b1 || rx_empty !== 1'b1) begin
            errors++; $display("FAIL drain_fifos_cleared got %b%b exp 11", tx_empty, rx_empty); end
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL drain_idle_while_busy got %b exp 0", idle); end
        l0 = n_load; bs0 = busy_store_err;
        push_byte(8'h6B);
        wait_idle(300, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL drain_restart_timeout got %b exp 1", ok); end
        checks++; if ((busy_store_err - bs0) != 0) begin
            errors++; $display("FAIL drain_store_while_busy got %0d exp 0", busy_store_err - bs0); end
        checks++; if ((n_load - l0) != 1 || last_store_data !== 8'h6B) begin
            errors++; $display("FAIL drain_new_transfer got %0d %h exp 1 6b", n_load - l0, last_store_data); end
        checks++; if (rx_empty !== 1'b0 || rd_data !== 8'h6B) begin
            errors++; $display("FAIL drain_rx got %b %h exp 0 6b", rx_empty, rd_data); end
        pop_byte();
        @(negedge cpu_clock);
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL drain_rx_drained got %b exp 1", rx_empty); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_overflow();
        test_rx_backpressure();
        test_pointer_wrap();
        test_reset_in_drain();
        checks++; if (order_err != 0 || multi_err != 0 || oe_err != 0) begin
            errors++; $display("FAIL strobe_protocol got %0d/%0d/%0d exp 0/0/0", order_err, multi_err, oe_err); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
